// File: rtl/btn_debounce_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_if
//
// Purpose: bundles the button debouncer's sampling strobe, raw inputs and
// cleaned outputs into one port so the debouncer and the game logic share a
// single connection.
//
// Signals (NBTN bits wide unless noted):
//   debounce_en  (1 bit) sampling strobe, driven by the master
//   btn_raw      raw asynchronous buttons, active-high, driven by the master
//   btn_level    debounced level, driven by the slave (debouncer)
//   btn_press    one-cycle press pulse, driven by the slave
//   btn_release  one-cycle release pulse, driven by the slave
//
// Modports:
//   master : the side that supplies buttons/strobe and consumes the results
//   slave  : the debouncer itself
// ---------------------------------------------------------------------------
interface btn_debounce_if #(
    parameter int NBTN = 4
) ();
    logic            debounce_en;
    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] btn_level;
    logic [NBTN-1:0] btn_press;
    logic [NBTN-1:0] btn_release;

    modport master (
        output debounce_en,
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  debounce_en,
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Purpose: synchronizes, debounces and edge-detects NBTN push buttons. Each
// button is sampled on the debounce_en strobe; STABLE_CNT consecutive samples
// that differ from the current level are needed before the level flips. A
// flip produces a one-cycle btn_press (rising) or btn_release (falling).
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset (clears every register)
//   bus  : btn_debounce_if.slave -- debounce_en, btn_raw in;
//          btn_level, btn_press, btn_release out (all registered)
//
// Parameters:
//   NBTN         number of buttons (>= 1)
//   STABLE_CNT   consecutive differing samples to accept a level (>= 1)
//   REPEAT_DELAY samples held before the first auto-repeat press
//   REPEAT_RATE  samples between further auto-repeat presses
//
// Configuration macro:
//   BTN_AUTOREPEAT_EN  when defined, a held button re-issues btn_press
//                      REPEAT_DELAY samples after the press, then every
//                      REPEAT_RATE samples. When undefined no repeat logic
//                      exists and a held button gives exactly one press.
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int NBTN         = 4,
    parameter int STABLE_CNT   = 4,
    parameter int REPEAT_DELAY = 100,
    parameter int REPEAT_RATE  = 20
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);

    localparam int CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    if (NBTN < 1 || STABLE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
        $error("btn_debounce: NBTN, STABLE_CNT, REPEAT_DELAY and REPEAT_RATE must all be >= 1");
    end

    typedef enum logic {
        RELEASED = 1'b0,
        HELD     = 1'b1
    } btn_state_t;

    logic [NBTN-1:0]  sync_p0;
    logic [NBTN-1:0]  sync_p1;
    btn_state_t       state   [NBTN];
    logic [CNT_W-1:0] cnt     [NBTN];
    logic [NBTN-1:0]  press_q;
    logic [NBTN-1:0]  release_q;

    logic [NBTN-1:0]  level;
    logic [NBTN-1:0]  differ;
    logic [NBTN-1:0]  accept;
    logic [NBTN-1:0]  rep_fire;

    // A button accepts a new level on the sample that completes a run of
    // STABLE_CNT differing samples; any agreeing sample restarts the run.
    always_comb begin
        level  = '0;
        differ = '0;
        accept = '0;
        for (int i = 0; i < NBTN; i++) begin
            level[i]  = (state[i] == HELD);
            differ[i] = sync_p1[i] ^ level[i];
            accept[i] = bus.debounce_en && differ[i] && (cnt[i] == CNT_LAST);
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    // Down-counter of samples until the next repeat press; loaded with
    // REPEAT_DELAY on acceptance of a press, reloaded with REPEAT_RATE each
    // time it fires, forced to 0 on release.
    logic [REP_W-1:0] rep_cnt [NBTN];

    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < NBTN; i++) begin
            rep_fire[i] = bus.debounce_en && (state[i] == HELD) && !accept[i] &&
                          (rep_cnt[i] == REP_W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                rep_cnt[i] <= '0;
            end
        end else if (bus.debounce_en) begin
            for (int i = 0; i < NBTN; i++) begin
                if (accept[i]) begin
                    rep_cnt[i] <= (state[i] == RELEASED) ? REP_W'(REPEAT_DELAY) : '0;
                end else if (state[i] == HELD) begin
                    if (rep_cnt[i] == REP_W'(1)) begin
                        rep_cnt[i] <= REP_W'(REPEAT_RATE);
                    end else if (rep_cnt[i] != '0) begin
                        rep_cnt[i] <= rep_cnt[i] - REP_W'(1);
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NBTN; i++) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
            end
        end else begin
            // stage p0/p1: two-flop synchronizer, runs every clock
            sync_p0 <= bus.btn_raw;
            sync_p1 <= sync_p0;

            // debounce stage: only advances on the sampling strobe
            press_q   <= '0;
            release_q <= '0;
            if (bus.debounce_en) begin
                for (int i = 0; i < NBTN; i++) begin
                    if (accept[i]) begin
                        cnt[i] <= '0;
                        if (state[i] == RELEASED) begin
                            state[i]   <= HELD;
                            press_q[i] <= 1'b1;
                        end else begin
                            state[i]     <= RELEASED;
                            release_q[i] <= 1'b1;
                        end
                    end else if (differ[i]) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end else begin
                        cnt[i] <= '0;
                    end
                    if (rep_fire[i]) begin
                        press_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.btn_level   = level;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;

endmodule

// File: tb/tb_btn_debounce.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce
//
// Directed bench for btn_debounce (NBTN=4, STABLE_CNT=4, REPEAT_DELAY=8,
// REPEAT_RATE=3). A sample-window model of the debouncer predicts the
// outputs after every clock edge; a compare process checks them 2 time units
// after each rising edge. Directed scenarios additionally pin the model with
// hand-computed pulse latencies and vectors.
// ---------------------------------------------------------------------------
module tb_btn_debounce;
    localparam int NBTN = 4;
    localparam int SC   = 4;
    localparam int RD   = 8;
    localparam int RR   = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    btn_debounce_if #(.NBTN(NBTN)) bus ();

    btn_debounce #(
        .NBTN(NBTN),
        .STABLE_CNT(SC),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level flips when the last STABLE_CNT samples taken since the previous
    // flip (or reset) all disagree with it. The sampled value is btn_raw as
    // it was two clock edges earlier. Auto-repeat presses occur when the
    // number of samples held since the press reaches RD, RD+RR, RD+2RR ...
    logic [NBTN-1:0] exp_level, exp_press, exp_release;
    logic [NBTN-1:0] raw_ago1, raw_ago2, seen;
    bit              win [NBTN][$];
    int              held_n [NBTN];
    bit              all_diff;

    initial begin
        exp_level = '0; exp_press = '0; exp_release = '0;
        raw_ago1 = '0; raw_ago2 = '0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                exp_level = '0; exp_press = '0; exp_release = '0;
                raw_ago1 = '0; raw_ago2 = '0;
                for (int i = 0; i < NBTN; i++) begin
                    win[i].delete();
                    held_n[i] = 0;
                end
            end else begin
                seen     = raw_ago2;
                raw_ago2 = raw_ago1;
                raw_ago1 = bus.btn_raw;
                exp_press   = '0;
                exp_release = '0;
                if (bus.debounce_en) begin
                    for (int i = 0; i < NBTN; i++) begin
                        win[i].push_back(seen[i]);
                        if (win[i].size() > SC) void'(win[i].pop_front());
                        all_diff = (win[i].size() == SC);
                        foreach (win[i][j]) if (win[i][j] == exp_level[i]) all_diff = 0;
                        if (all_diff) begin
                            win[i].delete();
                            exp_level[i] = ~exp_level[i];
                            if (exp_level[i]) begin
                                exp_press[i] = 1'b1;
                                held_n[i]    = 0;
                            end else begin
                                exp_release[i] = 1'b1;
                            end
                        end else if (exp_level[i]) begin
                            held_n[i]++;
`ifdef BTN_AUTOREPEAT_EN
                            if (held_n[i] >= RD && ((held_n[i] - RD) % RR) == 0)
                                exp_press[i] = 1'b1;
`endif
                        end
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("model_level",   bus.btn_level,   exp_level);
            check("model_press",   bus.btn_press,   exp_press);
            check("model_release", bus.btn_release, exp_release);
        end
    end

    // Watch n falling edges; report the first cycle where (pulse & mask) != 0,
    // the pulse vector on that cycle, and the number of such cycles.
    task automatic watch(input int n, input bit rel, input logic [NBTN-1:0] mask,
                         output int first, output logic [NBTN-1:0] vec, output int pulses,
                         output int d [$]);
        logic [NBTN-1:0] p;
        first = -1; vec = '0; pulses = 0; d.delete();
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            p = rel ? bus.btn_release : bus.btn_press;
            if ((p & mask) != '0) begin
                if (first < 0) begin
                    first = c;
                    vec   = p;
                end
                pulses++;
                d.push_back(c);
            end
        end
    endtask

    int              first, pulses, acc;
    logic [NBTN-1:0] vec;
    int              dl [$];

    typedef struct { logic [NBTN-1:0] raw; int hold; } vec_t;
    vec_t tbl [8];

    initial begin
        rst = 1'b1;
        bus.debounce_en = 1'b1;
        bus.btn_raw = '0;
        repeat (3) @(negedge clk);
        check("reset_level",   bus.btn_level,   4'b0000);
        check("reset_press",   bus.btn_press,   4'b0000);
        check("reset_release", bus.btn_release, 4'b0000);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Clean press on button 0, held 30 cycles (also the auto-repeat case)
        bus.btn_raw[0] = 1'b1;
        watch(30, 1'b0, 4'b0001, first, vec, pulses, dl);
        check("press0_latency", first, 6);
        check("press0_level", bus.btn_level[0], 1'b1);
`ifdef BTN_AUTOREPEAT_EN
        check("repeat_count", pulses, 7);
        check("repeat_1", dl[1], 14);
        check("repeat_2", dl[2], 17);
        check("repeat_3", dl[3], 20);
        check("repeat_4", dl[4], 23);
`else
        check("press0_single", pulses, 1);
`endif

        // Release of button 0
        bus.btn_raw[0] = 1'b0;
        watch(12, 1'b1, 4'b0001, first, vec, pulses, dl);
        check("release0_latency", first, 6);
        check("release0_count", pulses, 1);
        check("release0_level", bus.btn_level[0], 1'b0);
        repeat (12) @(negedge clk);
        watch(12, 1'b0, 4'b0001, first, vec, pulses, dl);
        check("after_release_no_press", pulses, 0);

        // Bounce on button 1: toggles every 2 cycles for 20 cycles, then 1
        acc = 0;
        for (int k = 0; k < 10; k++) begin
            bus.btn_raw[1] = ~bus.btn_raw[1];
            watch(2, 1'b0, 4'b0010, first, vec, pulses, dl);
            acc += pulses;
        end
        check("bounce_no_press", acc, 0);
        check("bounce_level", bus.btn_level[1], 1'b0);
        bus.btn_raw[1] = 1'b1;
        watch(12, 1'b0, 4'b0010, first, vec, pulses, dl);
        check("bounce_press_latency", first, 6);
        check("bounce_press_count", pulses, 1);

        // Simultaneous rise on buttons 1 and 3
        bus.btn_raw[1] = 1'b0;
        repeat (12) @(negedge clk);
        bus.btn_raw = bus.btn_raw | 4'b1010;
        watch(12, 1'b0, 4'b1010, first, vec, pulses, dl);
        check("simul_latency", first, 6);
        check("simul_vector", vec, 4'b1010);
        check("simul_cycles", pulses, 1);

        // Reset mid-count on button 2
        bus.btn_raw[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_level", bus.btn_level, 4'b1010);
        rst = 1'b1;
        #1;
        check("async_reset_level",   bus.btn_level,   4'b0000);
        check("async_reset_press",   bus.btn_press,   4'b0000);
        check("async_reset_release", bus.btn_release, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        watch(12, 1'b0, 4'b1110, first, vec, pulses, dl);
        check("post_reset_latency", first, 6);
        check("post_reset_vector", vec, 4'b1110);
        check("post_reset_level", bus.btn_level, 4'b1110);

        // Gated strobe: one sample every third cycle, mixed button patterns
        tbl[0] = '{4'b0000, 20}; tbl[1] = '{4'b0101, 25};
        tbl[2] = '{4'b0111, 4};  tbl[3] = '{4'b1111, 30};
        tbl[4] = '{4'b1001, 7};  tbl[5] = '{4'b0110, 40};
        tbl[6] = '{4'b1111, 60}; tbl[7] = '{4'b0000, 30};
        for (int t = 0; t < 8; t++) begin
            bus.btn_raw = tbl[t].raw;
            for (int c = 0; c < tbl[t].hold; c++) begin
                bus.debounce_en = ((c % 3) == 0);
                @(negedge clk);
            end
        end
        bus.debounce_en = 1'b1;
        repeat (10) @(negedge clk);
        check("final_level", bus.btn_level, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounces and edge-detects the raw push-button inputs of the snake game. Samples each synchronized button on the debounce sampling strobe from the clock-enable generator, nominally one pulse every 5 ms. Produces a clean level and single-cycle press/release pulses for the direction/control logic downstream. Each button is handled independently.

## Interface
Parameters:
- NBTN, 4: number of buttons (up, down, left, right); must be ≥ 1.
- STABLE_CNT, 4: consecutive differing samples required to accept a new level; must be ≥ 1.
- REPEAT_DELAY, 100: samples a button is held before the first auto-repeat press (500 ms at 5 ms/sample).
- REPEAT_RATE, 20: samples between subsequent auto-repeat presses.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- debounce_en  in  1  one-cycle sampling strobe; may be held high continuously, which samples every cycle.
- btn_raw  in  NBTN  asynchronous raw buttons, active-high.
- btn_level  out  NBTN  debounced level, registered.
- btn_press  out  NBTN  one-cycle pulse on an accepted 0→1 transition, and on auto-repeat.
- btn_release  out  NBTN  one-cycle pulse on an accepted 1→0 transition.

## Operation
- Each btn_raw bit passes through a 2-FF synchronizer clocked every clk, not gated by debounce_en.
- Per button, a sample counter of width $clog2(STABLE_CNT+1) behaves as follows on a cycle with debounce_en=1:
  - If the synchronized bit equals btn_level, the counter clears to 0.
  - If it differs and counter == STABLE_CNT-1: btn_level toggles, the counter clears, and btn_press (rising) or btn_release (falling) pulses.
  - If it differs otherwise, the counter increments.
- On a cycle with debounce_en=0, counters and levels hold, and pulse outputs are 0.
- A single agreeing sample discards all progress, so a glitch shorter than STABLE_CNT samples never changes btn_level.
- Buttons are independent. Any combination of press/release bits may assert in the same cycle.
- Per-button state is two-valued (RELEASED/HELD) and is exactly btn_level.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0, synchronizers=0, all counters=0.
  - Outputs clear asynchronously on rst assertion, including mid-count. A partial count is lost.
  - After release from reset, a full STABLE_CNT samples are needed again.
- btn_press and btn_release are registered. They are high for exactly the one clk cycle following the sampling edge that accepted the transition, and btn_level changes on that same edge.
- Minimum latency from a btn_raw edge to a btn_level change: 2 clk cycles of synchronization, then STABLE_CNT debounce_en samples.
- Continuous debounce_en=1 is legal. In that case the latency is 2+STABLE_CNT cycles.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Each button has a repeat counter that counts debounce_en samples while btn_level=1.
  - REPEAT_DELAY samples after the press pulse, btn_press pulses again, then every REPEAT_RATE samples while the button stays held.
  - The repeat counter clears on release and on rst.
  - btn_release is unaffected.
- BTN_AUTOREPEAT_EN undefined: no repeat logic is synthesized, and a held button yields exactly one btn_press.

## Test plan
Unless noted, use debounce_en=1 continuously, STABLE_CNT=4, NBTN=4.
- Clean press: btn_raw[0] 0→1 and held → btn_level[0]=1 and a single btn_press[0] pulse 6 cycles after the edge. No further pulses follow without autorepeat.
- Bounce: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays 1 → no pulse during bounce, then exactly one btn_press[1] 6 cycles after the last edge.
- Release: btn_raw[0] 1→0 held → btn_release[0] pulses once and btn_level[0]=0, 6 cycles later. btn_press[0] stays 0.
- Simultaneous: btn_raw[1] and btn_raw[3] rise on the same cycle → btn_press[1] and btn_press[3] are high on the same single cycle.
- Reset mid-operation: rst pulsed 3 samples after a btn_raw[2] rise → all outputs are 0 immediately. After rst deasserts with btn_raw[2] still 1, the press appears 6 cycles later.
- Autorepeat with BTN_AUTOREPEAT_EN defined, REPEAT_DELAY=8, REPEAT_RATE=3: hold btn_raw[0] → btn_press[0] pulses at acceptance, then at acceptance +8, +11, +14, +17 samples. With the macro undefined, there is only the first pulse.
